// File: rtl/run_scan_ctrl_if.sv
// Handshake and detector-side signals of the run scan controller.
// master: word source, result sink and detector; slave: the controller.
interface run_scan_ctrl_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
);
  // Word input handshake
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  // Result output handshake
  logic             out_valid;
  logic [CNT_W-1:0] out_x_cnt;
  logic [CNT_W-1:0] out_y_cnt;
  logic             out_ready;
  // Detector connection
  logic             det_din;
  logic             det_cen;
  logic             det_resetn;
  logic             det_doutx;
  logic             det_douty;

  modport master (
    output in_valid, in_data, out_ready, det_doutx, det_douty,
    input  in_ready, out_valid, out_x_cnt, out_y_cnt, det_din, det_cen, det_resetn
  );

  modport slave (
    input  in_valid, in_data, out_ready, det_doutx, det_douty,
    output in_ready, out_valid, out_x_cnt, out_y_cnt, det_din, det_cen, det_resetn
  );
endinterface

// File: rtl/run_scan_ctrl.sv
// Sequencing controller for the serial run detector: clears the detector,
// shifts a word in MSB-first and counts the cycles each detector flag is set.
module run_scan_ctrl #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned CLR_CYCLES = 2,
  parameter int unsigned CNT_W      = $clog2(WIDTH + 1)
) (
  input  logic           clk_i,
  input  logic           resetn_i,
  input  logic           flush_i,
  output logic           busy_o,
  run_scan_ctrl_if.slave bus
);

  localparam int unsigned ClrW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam int unsigned KW   = $clog2(WIDTH);

  typedef enum logic [2:0] {StIdle, StClear, StShift, StDrain, StReport} state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   shreg_q;
  logic [ClrW-1:0]    clr_cnt_q;
  logic [KW-1:0]      k_q;
  logic [CNT_W-1:0]   x_cnt_q;
  logic [CNT_W-1:0]   y_cnt_q;
  logic               det_din_q;
  logic               det_cen_q;
  logic               det_resetn_q;
  logic               out_valid_q;
  logic               busy_q;

  // Sequencer FSM; every output except in_ready is registered here.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q      <= StIdle;
      shreg_q      <= '0;
      clr_cnt_q    <= '0;
      k_q          <= '0;
      x_cnt_q      <= '0;
      y_cnt_q      <= '0;
      det_din_q    <= 1'b0;
      det_cen_q    <= 1'b0;
      det_resetn_q <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else if (flush_i) begin
      // Abort wins over everything, including an accept in the same cycle.
      state_q      <= StIdle;
      x_cnt_q      <= '0;
      y_cnt_q      <= '0;
      det_din_q    <= 1'b0;
      det_cen_q    <= 1'b0;
      det_resetn_q <= 1'b1;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          det_resetn_q <= 1'b1;
          if (bus.in_valid) begin
            state_q      <= StClear;
            shreg_q      <= bus.in_data;
            clr_cnt_q    <= '0;
            x_cnt_q      <= '0;
            y_cnt_q      <= '0;
            det_resetn_q <= 1'b0;
            det_cen_q    <= 1'b0;
            det_din_q    <= 1'b0;
            busy_q       <= 1'b1;
          end
        end
        StClear: begin
          if (clr_cnt_q == ClrW'(CLR_CYCLES - 1)) begin
            state_q      <= StShift;
            k_q          <= '0;
            det_resetn_q <= 1'b1;
            det_cen_q    <= 1'b1;
            det_din_q    <= shreg_q[WIDTH-1];
            shreg_q      <= {shreg_q[WIDTH-2:0], 1'b0};
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
        StShift: begin
          // The k=0 flags still show the freshly cleared detector.
          if (k_q != '0) begin
            x_cnt_q <= x_cnt_q + CNT_W'(bus.det_doutx);
            y_cnt_q <= y_cnt_q + CNT_W'(bus.det_douty);
          end
          if (k_q == KW'(WIDTH - 1)) begin
            state_q   <= StDrain;
            det_din_q <= 1'b0;
          end else begin
            k_q       <= k_q + 1'b1;
            det_din_q <= shreg_q[WIDTH-1];
            shreg_q   <= {shreg_q[WIDTH-2:0], 1'b0};
          end
        end
        StDrain: begin
          // Flags now reflect the detector state after the last bit.
          x_cnt_q     <= x_cnt_q + CNT_W'(bus.det_doutx);
          y_cnt_q     <= y_cnt_q + CNT_W'(bus.det_douty);
          state_q     <= StReport;
          det_cen_q   <= 1'b0;
          out_valid_q <= 1'b1;
        end
        StReport: begin
          if (bus.out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Output mapping; in_ready is the only combinational output.
  always_comb begin
    bus.in_ready   = (state_q == StIdle);
    bus.out_valid  = out_valid_q;
    bus.out_x_cnt  = x_cnt_q;
    bus.out_y_cnt  = y_cnt_q;
    bus.det_din    = det_din_q;
    bus.det_cen    = det_cen_q;
    bus.det_resetn = det_resetn_q;
    busy_o         = busy_q;
  end

endmodule
